fb_write_scheduler: RTL



---
 rtl/fb_pkg.sv | 35 +++
 rtl/rect_cmd_fifo.sv | 61 ++++++
 rtl/fb_write_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared framebuffer geometry, rectangle command record and
//               write-scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int ADDR_W   = 17;
  localparam int COLOR_W  = 6;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  // Rectangle bounds are exclusive on all four sides.
  typedef struct packed {
    logic [X_W-1:0]     x1;
    logic [X_W-1:0]     x2;
    logic [Y_W-1:0]     y1;
    logic [Y_W-1:0]     y2;
    logic [COLOR_W-1:0] color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FILL  = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rect_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rect_cmd_fifo
// Description : Synchronous FIFO of rectangle commands with occupancy count.
//               Head entry is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_cmd_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     push,
  input  rect_cmd_t                push_data,
  input  logic                     pop,
  output rect_cmd_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  rect_cmd_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == (PTR_W + 1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_scheduler
// Description : Owns the framebuffer write port. Queues rectangle fills and
//               emits one pixel write per cycle; a clear request preempts
//               any fill and wipes the whole screen to colour 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_scheduler #(
  parameter int DEPTH = 4,
  parameter int FB_W  = 320,
  parameter int FB_H  = 240
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   clear_req,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [8:0]             cmd_x1,
  input  logic [8:0]             cmd_x2,
  input  logic [7:0]             cmd_y1,
  input  logic [7:0]             cmd_y2,
  input  logic [5:0]             cmd_color,
  output logic                   wr_en,
  output logic [16:0]            wr_addr,
  output logic [5:0]             wr_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import fb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [ADDR_W-1:0] c_row_step  = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [X_W-1:0]    c_x_max     = X_W'(FB_W);
  localparam logic [Y_W-1:0]    c_y_max     = Y_W'(FB_H);

  state_t             r_state;
  logic [X_W-1:0]     r_x;
  logic [X_W-1:0]     r_x_first;
  logic [X_W-1:0]     r_x_last;
  logic [Y_W-1:0]     r_y;
  logic [Y_W-1:0]     r_y_last;
  logic [ADDR_W-1:0]  r_rowbase;

  rect_cmd_t          w_cmd;
  rect_cmd_t          w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_fifo_empty;
  logic               w_pending;
  logic               w_more;
  logic [X_W-1:0]     w_x2c;
  logic [Y_W-1:0]     w_y2c;
  logic [X_W-1:0]     w_x_first;
  logic [Y_W-1:0]     w_y_first;
  logic               w_empty_rect;
  logic [ADDR_W-1:0]  w_rowbase0;
  logic               w_row_end;
  logic               w_last_px;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  // The head is consumed in LOAD whatever happens next, so a clear arriving
  // during LOAD drops that command just like an interrupted fill.
  assign w_pop     = (r_state == LOAD);
  assign busy      = (r_state != IDLE);

  // Work is waiting either in the FIFO or arriving this very cycle.
  assign w_pending = !w_fifo_empty || w_push;
  // From LOAD: something remains after the current head is popped.
  assign w_more    = (fifo_count > CNT_W'(1)) || w_push;

  assign w_row_end = (r_x == r_x_last);
  assign w_last_px = w_row_end && (r_y == r_y_last);

  // Pack incoming command fields into the FIFO record.
  always_comb begin
    w_cmd       = '0;
    w_cmd.x1    = cmd_x1;
    w_cmd.x2    = cmd_x2;
    w_cmd.y1    = cmd_y1;
    w_cmd.y2    = cmd_y2;
    w_cmd.color = cmd_color;
  end

  // Clamp the head command to the screen and derive the first pixel/row base.
  always_comb begin
    w_x2c        = (w_head.x2 > c_x_max) ? c_x_max : w_head.x2;
    w_y2c        = (w_head.y2 > c_y_max) ? c_y_max : w_head.y2;
    w_x_first    = w_head.x1 + X_W'(1);
    w_y_first    = w_head.y1 + Y_W'(1);
    // Widened compare so x1=511 / y1=255 cannot wrap into a bogus region.
    w_empty_rect = ({1'b0, w_x2c} <= ({1'b0, w_head.x1} + (X_W + 1)'(1))) ||
                   ({1'b0, w_y2c} <= ({1'b0, w_head.y1} + (Y_W + 1)'(1)));
    w_rowbase0   = (ADDR_W'(w_head.y1) + ADDR_W'(1)) * c_row_step;
  end

  rect_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_cmd),
    .pop       (w_pop),
    .head      (w_head),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_fifo_empty)
  );

  // Scheduler FSM; write outputs describe the pixel written in the current cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      r_x       <= '0;
      r_x_first <= '0;
      r_x_last  <= '0;
      r_y       <= '0;
      r_y_last  <= '0;
      r_rowbase <= '0;
    end else if (clear_req) begin
      r_state <= CLEAR;
      wr_en   <= 1'b1;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          wr_en <= 1'b0;
          if (w_pending) r_state <= LOAD;
        end

        LOAD: begin
          r_x_first <= w_x_first;
          r_x_last  <= w_x2c - X_W'(1);
          r_y_last  <= w_y2c - Y_W'(1);
          r_x       <= w_x_first;
          r_y       <= w_y_first;
          r_rowbase <= w_rowbase0;
          if (w_empty_rect) begin
            wr_en   <= 1'b0;
            r_state <= w_more ? LOAD : IDLE;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= w_rowbase0 + ADDR_W'(w_x_first);
            wr_data <= w_head.color;
            r_state <= FILL;
          end
        end

        FILL: begin
          if (w_last_px) begin
            wr_en   <= 1'b0;
            r_state <= w_pending ? LOAD : IDLE;
          end else if (w_row_end) begin
            r_x       <= r_x_first;
            r_y       <= r_y + Y_W'(1);
            r_rowbase <= r_rowbase + c_row_step;
            wr_addr   <= r_rowbase + c_row_step + ADDR_W'(r_x_first);
          end else begin
            r_x     <= r_x + X_W'(1);
            wr_addr <= r_rowbase + ADDR_W'(r_x) + ADDR_W'(1);
          end
        end

        CLEAR: begin
          if (wr_addr == c_last_addr) begin
            wr_en   <= 1'b0;
            r_state <= w_pending ? LOAD : IDLE;
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end

        default: begin
          wr_en   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
